// File: rtl/word_packer_pkg.sv
// Bit layout of the packed 32-bit word, shared with the field splitter so the two cannot diverge.
package word_packer_pkg;

    localparam int F16_LSB = 0;
    localparam int F16_W   = 16;
    localparam int F8_LSB  = 16;
    localparam int F8_W    = 8;
    localparam int F1_BIT  = 24;
    localparam int PAD_LSB = 25;
    localparam int WORD_W  = 32;
    localparam int PAD_W   = WORD_W - PAD_LSB;
    localparam int OVF_W   = 8;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [PAD_W-1:0] pad,
        input logic             f1,
        input logic [F8_W-1:0]  f8,
        input logic [F16_W-1:0] f16
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[F16_LSB +: F16_W] = f16;
        w[F8_LSB +: F8_W]   = f8;
        w[F1_BIT]           = f1;
        w[PAD_LSB +: PAD_W] = pad;
        return w;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with registered count; head entry is read combinationally from storage.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even if a pop happens the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/word_packer.sv
// Collects a 16-bit field, an 8-bit field and a flag under independent handshakes and
// packs them into one 32-bit word drained through a small output FIFO.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int               DEPTH = 2,
    parameter logic [PAD_W-1:0] PAD   = 7'b0000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [F16_W-1:0]  in_16,
    input  logic              in_16_valid,
    output logic              in_16_ready,
    input  logic [F8_W-1:0]   in_8,
    input  logic              in_8_valid,
    output logic              in_8_ready,
    input  logic              in_1,
    input  logic              in_1_valid,
    output logic              in_1_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OVF_W-1:0]  overflow_cnt
);

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == {OVF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [F16_W-1:0] r16_q, r16_d;
    logic [F8_W-1:0]  r8_q, r8_d;
    logic             r1_q, r1_d;
    logic             p16_q, p16_d;
    logic             p8_q, p8_d;
    logic             p1_q, p1_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic             complete;
    logic             push;
    logic             pop;
    logic             acc16, acc8, acc1;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WORD_W-1:0] push_word;

    // fifo_full is a decode of registered count, so readies never see out_ready.
    assign complete    = p16_q & p8_q & p1_q;
    assign push        = complete & ~fifo_full;
    assign in_16_ready = ~p16_q | push;
    assign in_8_ready  = ~p8_q | push;
    assign in_1_ready  = ~p1_q | push;

    assign acc16 = in_16_valid & in_16_ready;
    assign acc8  = in_8_valid & in_8_ready;
    assign acc1  = in_1_valid & in_1_ready;

    assign out_valid    = ~fifo_empty;
    assign pop          = out_valid & out_ready;
    assign push_word    = pack_word(PAD, r1_q, r8_q, r16_q);
    assign overflow_cnt = ovf_q;

    always_comb begin
        r16_d = acc16 ? in_16 : r16_q;
        r8_d  = acc8 ? in_8 : r8_q;
        r1_d  = acc1 ? in_1 : r1_q;
        // On a push each flag reflects only what arrived this cycle, enabling back-to-back words.
        if (push) begin
            p16_d = acc16;
            p8_d  = acc8;
            p1_d  = acc1;
        end else begin
            p16_d = p16_q | acc16;
            p8_d  = p8_q | acc8;
            p1_d  = p1_q | acc1;
        end
        ovf_d = (complete & fifo_full) ? sat_inc(ovf_q) : ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r16_q <= '0;
            r8_q  <= '0;
            r1_q  <= 1'b0;
            p16_q <= 1'b0;
            p8_q  <= 1'b0;
            p1_q  <= 1'b0;
            ovf_q <= '0;
        end else begin
            r16_q <= r16_d;
            r8_q  <= r8_d;
            r1_q  <= r1_d;
            p16_q <= p16_d;
            p8_q  <= p8_d;
            p1_q  <= p1_d;
            ovf_q <= ovf_d;
        end
    end

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (out_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: latency, ordering, back-pressure, streaming, reset and pad.
module tb_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_16;
    logic        in_16_valid, in_16_ready;
    logic [7:0]  in_8;
    logic        in_8_valid, in_8_ready;
    logic        in_1;
    logic        in_1_valid, in_1_ready;
    logic [31:0] out_word;
    logic        out_valid, out_ready;
    logic [7:0]  overflow_cnt;

    logic [15:0] p_in_16;
    logic        p_in_16_valid, p_in_16_ready;
    logic [7:0]  p_in_8;
    logic        p_in_8_valid, p_in_8_ready;
    logic        p_in_1;
    logic        p_in_1_valid, p_in_1_ready;
    logic [31:0] p_out_word;
    logic        p_out_valid, p_out_ready;
    logic [7:0]  p_overflow_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [16];

    always #5 clk = ~clk;

    word_packer #(.DEPTH(2), .PAD(7'h00)) dut (
        .clk(clk), .rst(rst),
        .in_16(in_16), .in_16_valid(in_16_valid), .in_16_ready(in_16_ready),
        .in_8(in_8), .in_8_valid(in_8_valid), .in_8_ready(in_8_ready),
        .in_1(in_1), .in_1_valid(in_1_valid), .in_1_ready(in_1_ready),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .overflow_cnt(overflow_cnt)
    );

    word_packer #(.DEPTH(2), .PAD(7'h55)) dut_pad (
        .clk(clk), .rst(rst),
        .in_16(p_in_16), .in_16_valid(p_in_16_valid), .in_16_ready(p_in_16_ready),
        .in_8(p_in_8), .in_8_valid(p_in_8_valid), .in_8_ready(p_in_8_ready),
        .in_1(p_in_1), .in_1_valid(p_in_1_valid), .in_1_ready(p_in_1_ready),
        .out_word(p_out_word), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .overflow_cnt(p_overflow_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_readies(input string tag, input logic exp);
        chk1({tag, "_rdy16"}, in_16_ready, exp);
        chk1({tag, "_rdy8"}, in_8_ready, exp);
        chk1({tag, "_rdy1"}, in_1_ready, exp);
    endtask

    task automatic drive_set(input logic [15:0] f16, input logic [7:0] f8, input logic f1);
        in_16 = f16; in_8 = f8; in_1 = f1;
        in_16_valid = 1'b1; in_8_valid = 1'b1; in_1_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        in_16_valid = 1'b0; in_8_valid = 1'b0; in_1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_16 = '0; in_8 = '0; in_1 = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        p_in_16 = '0; p_in_8 = '0; p_in_1 = 1'b0;
        p_in_16_valid = 1'b0; p_in_8_valid = 1'b0; p_in_1_valid = 1'b0;
        p_out_ready = 1'b0;

        // ---- reset state ----
        tick();
        chk_readies("rst", 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_word", out_word, 32'h0);
        chk8("rst_ovf", overflow_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // ---- single word: 2-cycle latency, one cycle of out_valid ----
        out_ready = 1'b1;
        drive_set(16'hBEEF, 8'h5A, 1'b1);
        tick();
        idle_inputs();
        chk1("single_c1_valid", out_valid, 1'b0);
        tick();
        chk1("single_c2_valid", out_valid, 1'b1);
        chk32("single_c2_word", out_word, 32'h015ABEEF);
        tick();
        chk1("single_c3_valid", out_valid, 1'b0);

        // ---- out-of-order arrival ----
        in_1 = 1'b0; in_1_valid = 1'b1;
        tick();
        in_1_valid = 1'b0;
        chk1("ooo_c1_rdy1", in_1_ready, 1'b0);
        tick();
        in_1 = 1'b1; in_1_valid = 1'b1;
        chk1("ooo_c2_rdy1", in_1_ready, 1'b0);
        tick();
        in_1_valid = 1'b0;
        in_8 = 8'h12; in_8_valid = 1'b1;
        tick();
        in_8_valid = 1'b0;
        chk1("ooo_c4_rdy1", in_1_ready, 1'b0);
        chk1("ooo_c4_rdy8", in_8_ready, 1'b0);
        tick();
        in_16 = 16'h3456; in_16_valid = 1'b1;
        tick();
        in_16_valid = 1'b0;
        chk1("ooo_c6_valid", out_valid, 1'b0);
        tick();
        chk1("ooo_c7_valid", out_valid, 1'b1);
        chk32("ooo_c7_word", out_word, 32'h00123456);
        tick();
        chk1("ooo_c8_valid", out_valid, 1'b0);

        // ---- back-pressure with DEPTH=2 ----
        out_ready = 1'b0;
        drive_set(16'h1111, 8'h22, 1'b1);
        tick();
        drive_set(16'h2222, 8'h33, 1'b0);
        tick();
        drive_set(16'h3333, 8'h44, 1'b1);
        tick();
        idle_inputs();
        chk_readies("bp_c3", 1'b0);
        chk1("bp_c3_valid", out_valid, 1'b1);
        chk32("bp_c3_word", out_word, 32'h01221111);
        chk8("bp_c3_ovf", overflow_cnt, 8'd0);
        tick();
        chk8("bp_c4_ovf", overflow_cnt, 8'd1);
        tick();
        chk8("bp_c5_ovf", overflow_cnt, 8'd2);
        chk_readies("bp_c5", 1'b0);
        tick();
        chk8("bp_c6_ovf", overflow_cnt, 8'd3);
        out_ready = 1'b1;
        tick();
        chk32("bp_c7_word", out_word, 32'h00332222);
        chk8("bp_c7_ovf", overflow_cnt, 8'd4);
        chk_readies("bp_c7", 1'b1);
        tick();
        chk1("bp_c8_valid", out_valid, 1'b1);
        chk32("bp_c8_word", out_word, 32'h01443333);
        tick();
        chk1("bp_c9_valid", out_valid, 1'b0);
        chk8("bp_c9_ovf", overflow_cnt, 8'd4);

        // ---- streaming: 16 sets back to back ----
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = {7'd0, i[0], 8'(i * 3 + 1), 16'(i * 16'h1357 + 16'h0101)};
        end
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                drive_set(16'(c * 16'h1357 + 16'h0101), 8'(c * 3 + 1), c[0]);
            end else begin
                idle_inputs();
            end
            if (c >= 2) begin
                chk1($sformatf("stream_valid_%0d", c - 2), out_valid, 1'b1);
                chk32($sformatf("stream_word_%0d", c - 2), out_word, exp_q[c - 2]);
            end
            tick();
        end
        idle_inputs();
        chk1("stream_end_valid", out_valid, 1'b0);

        // ---- asynchronous reset mid-collection ----
        out_ready = 1'b0;
        drive_set(16'h0F0F, 8'hF0, 1'b1);
        tick();
        idle_inputs();
        tick();
        in_16 = 16'hDEAD; in_16_valid = 1'b1;
        in_8 = 8'hEE; in_8_valid = 1'b1;
        tick();
        idle_inputs();
        chk1("mid_valid", out_valid, 1'b1);
        chk32("mid_word", out_word, 32'h01F00F0F);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_valid", out_valid, 1'b0);
        chk_readies("arst", 1'b1);
        chk8("arst_ovf", overflow_cnt, 8'd0);
        chk32("arst_word", out_word, 32'h0);
        #2;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        in_1 = 1'b1; in_1_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk1("post_rst_no_stale", out_valid, 1'b0);
        in_16 = 16'hCAFE; in_16_valid = 1'b1;
        in_8 = 8'h77; in_8_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk1("post_rst_valid", out_valid, 1'b1);
        chk32("post_rst_word", out_word, 32'h0177CAFE);
        tick();

        // ---- PAD constant on an all-zero set ----
        p_out_ready = 1'b1;
        p_in_16_valid = 1'b1; p_in_8_valid = 1'b1; p_in_1_valid = 1'b1;
        tick();
        p_in_16_valid = 1'b0; p_in_8_valid = 1'b0; p_in_1_valid = 1'b0;
        tick();
        chk1("pad_valid", p_out_valid, 1'b1);
        chk32("pad_word", p_out_word, 32'hAA000000);
        tick();

        // ---- overflow counter saturation ----
        p_out_ready = 1'b0;
        p_in_16_valid = 1'b1; p_in_8_valid = 1'b1; p_in_1_valid = 1'b1;
        for (int k = 0; k < 270; k++) begin
            tick();
        end
        chk8("ovf_saturate", p_overflow_cnt, 8'd255);
        chk1("ovf_rdy_low", p_in_16_ready, 1'b0);
        chk32("ovf_head", p_out_word, 32'hAA000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
